// File: rtl/ats_eligibility_calc.sv
// ---------------------------------------------------------------------------
// ats_eligibility_calc
//
// Per-frame ATS (802.1Qcr token-bucket) eligibility-time stage. It accepts one
// frame descriptor at a time and requests the flow parameters from the
// flow-entry manager. From those parameters it computes the frame's
// eligibility time and decides whether the frame passes or is discarded. For a
// passing frame it writes back the new bucket-empty and group-eligibility
// times. The result goes downstream over a valid/ready handshake. Only one
// transaction is in flight at any time.
//
// Optional feature macro: ATS_STATS_EN adds saturating pass/drop counters.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_ready          descriptor handshake (in_ready only in IDLE)
//   in_flow_id, in_group_id    descriptor ids
//   in_frame_len               frame length, bytes
//   in_arrival_time            arrival timestamp, ps
//   start_match_flag           one-cycle lookup request to the manager
//   flow_id, group_id          held descriptor ids, to the manager
//   update_flag                one-cycle write-back request to the manager
//   update_bucket_empty_time   new bucket-empty time
//   update_group_eligibility_time  new group eligibility time
//   match_finish_flag          lookup result valid (held 2 cycles by manager)
//   bucket_size, token_rate    bucket parameters (bytes, ps per byte)
//   bucket_empty_time, group_eligibility_time, max_residence_time  from manager
//   out_valid/out_ready        result handshake
//   out_flow_id, out_group_id  ids of the result
//   out_eligibility_time       computed eligibility time
//   out_discard, out_timeout   drop decision / lookup timed out
//   stat_pass_cnt, stat_drop_cnt  (ATS_STATS_EN only) saturating counters
// ---------------------------------------------------------------------------
module ats_eligibility_calc #(
    parameter int TIME_WIDTH    = 59,
    parameter int LEN_WIDTH     = 16,
    parameter int MATCH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_flow_id,
    input  logic [4:0]            in_group_id,
    input  logic [LEN_WIDTH-1:0]  in_frame_len,
    input  logic [TIME_WIDTH-1:0] in_arrival_time,
    output logic                  start_match_flag,
    output logic [31:0]           flow_id,
    output logic [4:0]            group_id,
    output logic                  update_flag,
    output logic [TIME_WIDTH-1:0] update_bucket_empty_time,
    output logic [TIME_WIDTH-1:0] update_group_eligibility_time,
    input  logic                  match_finish_flag,
    input  logic [31:0]           bucket_size,
    input  logic [31:0]           token_rate,
    input  logic [TIME_WIDTH-1:0] bucket_empty_time,
    input  logic [TIME_WIDTH-1:0] group_eligibility_time,
    input  logic [TIME_WIDTH-1:0] max_residence_time,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_flow_id,
    output logic [4:0]            out_group_id,
    output logic [TIME_WIDTH-1:0] out_eligibility_time,
    output logic                  out_discard,
    output logic                  out_timeout
`ifdef ATS_STATS_EN
    ,
    output logic [31:0]           stat_pass_cnt,
    output logic [31:0]           stat_drop_cnt
`endif
);

    localparam int PROD_W = LEN_WIDTH + 32;
    localparam int CNT_W  = $clog2(MATCH_TIMEOUT + 1);
    localparam logic [TIME_WIDTH-1:0] TIME_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MATCH_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_MATCH,
        S_CALC1,
        S_CALC2,
        S_CALC3,
        S_WAIT_MGR,
        S_UPDATE,
        S_UPD_HOLD,
        S_OUTPUT
    } state_t;

    // Unsigned add that clamps to all-ones instead of wrapping.
    function automatic logic [TIME_WIDTH-1:0] sat_add(input logic [TIME_WIDTH-1:0] a,
                                                      input logic [TIME_WIDTH-1:0] b);
        logic [TIME_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TIME_WIDTH] ? TIME_MAX : s[TIME_WIDTH-1:0];
    endfunction

    // Clamp a 64-bit product into the time width.
    function automatic logic [TIME_WIDTH-1:0] sat_prod(input logic [63:0] p);
        return (p > 64'(TIME_MAX)) ? TIME_MAX : p[TIME_WIDTH-1:0];
    endfunction

    state_t                state;
    logic [CNT_W-1:0]      timeout_cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [TIME_WIDTH-1:0] arrival_q;
    logic [31:0]           bucket_size_q;
    logic [31:0]           token_rate_q;
    logic [TIME_WIDTH-1:0] be_q;         // bucket_empty_time from manager
    logic [TIME_WIDTH-1:0] ge_q;         // group_eligibility_time from manager
    logic [TIME_WIDTH-1:0] mr_q;         // max_residence_time, 0 = unlimited
    logic [TIME_WIDTH-1:0] lrd_q;        // length * rate
    logic [TIME_WIDTH-1:0] etf_q;        // time to fill an empty bucket
    logic [TIME_WIDTH-1:0] sched_q;
    logic [TIME_WIDTH-1:0] full_q;
    logic [TIME_WIDTH-1:0] limit_q;

    logic [PROD_W-1:0]     lrd_full;
    logic [63:0]           etf_full;
    logic [TIME_WIDTH-1:0] elig_c;
    logic [TIME_WIDTH-1:0] max_ag_c;
    logic                  discard_c;
    logic [TIME_WIDTH-1:0] new_empty_c;

    assign lrd_full = PROD_W'(len_q) * PROD_W'(token_rate_q);
    assign etf_full = 64'(bucket_size_q) * 64'(token_rate_q);

    // Results are reported from the held descriptor ids; they cannot change
    // before the output handshake because no new frame is accepted earlier.
    assign out_flow_id  = flow_id;
    assign out_group_id = group_id;

    always_comb begin
        max_ag_c    = (arrival_q > ge_q) ? arrival_q : ge_q;
        elig_c      = (max_ag_c > sched_q) ? max_ag_c : sched_q;
        discard_c   = (mr_q != '0) && (elig_c > limit_q);
        // Tokens beyond a full bucket are lost, so the empty time is pushed
        // forward by however long the bucket sat full before this frame.
        new_empty_c = (elig_c < full_q) ? sched_q : sat_add(sched_q, elig_c - full_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                         <= S_IDLE;
            in_ready                      <= 1'b0;
            start_match_flag              <= 1'b0;
            flow_id                       <= '0;
            group_id                      <= '0;
            update_flag                   <= 1'b0;
            update_bucket_empty_time      <= '0;
            update_group_eligibility_time <= '0;
            out_valid                     <= 1'b0;
            out_eligibility_time          <= '0;
            out_discard                   <= 1'b0;
            out_timeout                   <= 1'b0;
            timeout_cnt                   <= '0;
            len_q                         <= '0;
            arrival_q                     <= '0;
            bucket_size_q                 <= '0;
            token_rate_q                  <= '0;
            be_q                          <= '0;
            ge_q                          <= '0;
            mr_q                          <= '0;
            lrd_q                         <= '0;
            etf_q                         <= '0;
            sched_q                       <= '0;
            full_q                        <= '0;
            limit_q                       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // in_ready is raised one cycle after entering IDLE from reset.
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        flow_id          <= in_flow_id;
                        group_id         <= in_group_id;
                        len_q            <= in_frame_len;
                        arrival_q        <= in_arrival_time;
                        in_ready         <= 1'b0;
                        start_match_flag <= 1'b1;
                        state            <= S_REQ;
                    end
                end
                S_REQ: begin
                    start_match_flag <= 1'b0;
                    timeout_cnt      <= '0;
                    state            <= S_WAIT_MATCH;
                end
                S_WAIT_MATCH: begin
                    if (match_finish_flag) begin
                        bucket_size_q <= bucket_size;
                        token_rate_q  <= token_rate;
                        be_q          <= bucket_empty_time;
                        ge_q          <= group_eligibility_time;
                        mr_q          <= max_residence_time;
                        state         <= S_CALC1;
                    end else if (timeout_cnt == CNT_LAST) begin
                        out_eligibility_time <= '0;
                        out_discard          <= 1'b1;
                        out_timeout          <= 1'b1;
                        out_valid            <= 1'b1;
                        state                <= S_OUTPUT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_CALC1: begin
                    lrd_q <= sat_prod(64'(lrd_full));
                    etf_q <= sat_prod(etf_full);
                    state <= S_CALC2;
                end
                S_CALC2: begin
                    sched_q <= sat_add(be_q, lrd_q);
                    full_q  <= sat_add(be_q, etf_q);
                    limit_q <= sat_add(arrival_q, mr_q);
                    state   <= S_CALC3;
                end
                S_CALC3: begin
                    out_eligibility_time <= elig_c;
                    out_discard          <= discard_c;
                    out_timeout          <= 1'b0;
                    if (!discard_c) begin
                        update_bucket_empty_time      <= new_empty_c;
                        update_group_eligibility_time <= elig_c;
                    end
                    state <= S_WAIT_MGR;
                end
                S_WAIT_MGR: begin
                    // The manager drops match_finish_flag once it is back in
                    // IDLE and able to take the write-back.
                    if (!match_finish_flag) begin
                        if (out_discard) begin
                            out_valid <= 1'b1;
                            state     <= S_OUTPUT;
                        end else begin
                            update_flag <= 1'b1;
                            state       <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    update_flag <= 1'b0;
                    state       <= S_UPD_HOLD;
                end
                S_UPD_HOLD: begin
                    out_valid <= 1'b1;
                    state     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ATS_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pass_cnt <= '0;
            stat_drop_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_discard) begin
                if (stat_drop_cnt != 32'hFFFF_FFFF) stat_drop_cnt <= stat_drop_cnt + 1'b1;
            end else begin
                if (stat_pass_cnt != 32'hFFFF_FFFF) stat_pass_cnt <= stat_pass_cnt + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ats_eligibility_calc.sv
module tb_ats_eligibility_calc;

    localparam int TW  = 59;
    localparam int LW  = 16;
    localparam int MTO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_flow_id = '0;
    logic [4:0]    in_group_id = '0;
    logic [LW-1:0] in_frame_len = '0;
    logic [TW-1:0] in_arrival_time = '0;
    logic          start_match_flag;
    logic [31:0]   flow_id;
    logic [4:0]    group_id;
    logic          update_flag;
    logic [TW-1:0] update_bucket_empty_time;
    logic [TW-1:0] update_group_eligibility_time;
    logic          match_finish_flag = 1'b0;
    logic [31:0]   bucket_size = '0;
    logic [31:0]   token_rate = '0;
    logic [TW-1:0] bucket_empty_time = '0;
    logic [TW-1:0] group_eligibility_time = '0;
    logic [TW-1:0] max_residence_time = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_flow_id;
    logic [4:0]    out_group_id;
    logic [TW-1:0] out_eligibility_time;
    logic          out_discard;
    logic          out_timeout;
`ifdef ATS_STATS_EN
    logic [31:0]   stat_pass_cnt;
    logic [31:0]   stat_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor state, sampled on the falling edge.
    int            upd_cnt = 0;
    int            ov_cnt = 0;
    logic          upd_prev = 1'b0;
    logic [TW-1:0] upd_empty = '0;
    logic [TW-1:0] upd_group = '0;

    logic [256:0] all_outs;
    assign all_outs = {in_ready, start_match_flag, flow_id, group_id, update_flag,
                       update_bucket_empty_time, update_group_eligibility_time,
                       out_valid, out_flow_id, out_group_id, out_eligibility_time,
                       out_discard, out_timeout};

    ats_eligibility_calc #(.TIME_WIDTH(TW), .LEN_WIDTH(LW), .MATCH_TIMEOUT(MTO)) dut (
        .clk                           (clk),
        .reset                         (reset),
        .in_valid                      (in_valid),
        .in_ready                      (in_ready),
        .in_flow_id                    (in_flow_id),
        .in_group_id                   (in_group_id),
        .in_frame_len                  (in_frame_len),
        .in_arrival_time               (in_arrival_time),
        .start_match_flag              (start_match_flag),
        .flow_id                       (flow_id),
        .group_id                      (group_id),
        .update_flag                   (update_flag),
        .update_bucket_empty_time      (update_bucket_empty_time),
        .update_group_eligibility_time (update_group_eligibility_time),
        .match_finish_flag             (match_finish_flag),
        .bucket_size                   (bucket_size),
        .token_rate                    (token_rate),
        .bucket_empty_time             (bucket_empty_time),
        .group_eligibility_time        (group_eligibility_time),
        .max_residence_time            (max_residence_time),
        .out_valid                     (out_valid),
        .out_ready                     (out_ready),
        .out_flow_id                   (out_flow_id),
        .out_group_id                  (out_group_id),
        .out_eligibility_time          (out_eligibility_time),
        .out_discard                   (out_discard),
        .out_timeout                   (out_timeout)
`ifdef ATS_STATS_EN
        ,
        .stat_pass_cnt                 (stat_pass_cnt),
        .stat_drop_cnt                 (stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Counts update pulses and out_valid cycles, and checks that the
    // write-back values stay put in the cycle after the update pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (upd_prev) begin
                checks++;
                if (update_bucket_empty_time !== upd_empty || update_group_eligibility_time !== upd_group) begin
                    errors++;
                    $display("FAIL upd_hold_stable: got empty=%0d group=%0d, want empty=%0d group=%0d",
                             update_bucket_empty_time, update_group_eligibility_time, upd_empty, upd_group);
                end
            end
            if (update_flag) begin
                upd_cnt++;
                upd_empty = update_bucket_empty_time;
                upd_group = update_group_eligibility_time;
            end
            if (out_valid) ov_cnt++;
            upd_prev = update_flag;
        end else begin
            upd_prev = 1'b0;
        end
    end

    // Drives one descriptor, plays the manager, stalls out_ready five
    // cycles and completes the output handshake.
    task automatic run_frame(input string name, input logic [31:0] fid, input logic [4:0] gid,
                             input logic [TW-1:0] arr, input logic [TW-1:0] be,
                             input logic [TW-1:0] ge, input logic [TW-1:0] mr,
                             input bit respond, input logic [TW-1:0] exp_elig,
                             input logic exp_disc, input logic exp_to, input int exp_upd,
                             input logic [TW-1:0] exp_empty, input logic [TW-1:0] exp_grp);
        int n;
        logic stable;
        logic [TW-1:0] held_elig;
        upd_cnt = 0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_flow_id = fid; in_group_id = gid;
        in_frame_len = 16'd1500; in_arrival_time = arr;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (start_match_flag !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (start_match_flag !== 1'b1 || flow_id !== fid || group_id !== gid) begin
            errors++;
            $display("FAIL %s lookup_req: got start=%b flow=%h group=%0d want 1 %h %0d",
                     name, start_match_flag, flow_id, group_id, fid, gid);
        end
        @(negedge clk);
        checks++;
        if (start_match_flag !== 1'b0) begin
            errors++; $display("FAIL %s start_pulse_width: got %b want 0", name, start_match_flag);
        end
        if (respond) begin
            bucket_size = 32'd3200; token_rate = 32'd160000;
            bucket_empty_time = be; group_eligibility_time = ge; max_residence_time = mr;
            match_finish_flag = 1'b1;
            repeat (2) @(negedge clk);
            match_finish_flag = 1'b0;
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL %s out_valid_timeout: got %b want 1", name, out_valid);
        end
        if (!respond) begin
            checks++;
            if (n < MTO - 2) begin
                errors++; $display("FAIL %s timeout_wait: got %0d cycles want >= %0d", name, n, MTO - 2);
            end
        end
        checks++;
        if (out_eligibility_time !== exp_elig) begin
            errors++; $display("FAIL %s elig: got %0d want %0d", name, out_eligibility_time, exp_elig);
        end
        checks++;
        if (out_discard !== exp_disc || out_timeout !== exp_to) begin
            errors++; $display("FAIL %s discard/timeout: got %b/%b want %b/%b",
                               name, out_discard, out_timeout, exp_disc, exp_to);
        end
        checks++;
        if (out_flow_id !== fid || out_group_id !== gid) begin
            errors++; $display("FAIL %s out_ids: got %h/%0d want %h/%0d", name, out_flow_id, out_group_id, fid, gid);
        end
        checks++;
        if (upd_cnt !== exp_upd) begin
            errors++; $display("FAIL %s update_count: got %0d want %0d", name, upd_cnt, exp_upd);
        end
        if (exp_upd != 0) begin
            checks++;
            if (upd_empty !== exp_empty || upd_group !== exp_grp) begin
                errors++; $display("FAIL %s update_values: got %0d/%0d want %0d/%0d",
                                   name, upd_empty, upd_group, exp_empty, exp_grp);
            end
        end
        held_elig = out_eligibility_time;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_eligibility_time !== held_elig || out_discard !== exp_disc) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++; $display("FAIL %s stall_stable: got %b want 1", name, stable);
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL %s in_ready_handshake: got %b want 0", name, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s after_handshake: got valid=%b ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_rise: got %b want 1", in_ready);
        end
`ifdef ATS_STATS_EN
        checks++;
        if (stat_pass_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_pass_cnt, stat_drop_cnt);
        end
`endif
    endtask

    task automatic test_first_frame();
        run_frame("first", 32'h11, 5'd3, 59'd1_000_000_000, 59'd0, 59'd0, 59'd0, 1'b1,
                  59'd1_000_000_000, 1'b0, 1'b0, 1, 59'd728_000_000, 59'd1_000_000_000);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b", 32'h22, 5'd3, 59'd1_000_000_100, 59'd728_000_000, 59'd1_000_000_000, 59'd0, 1'b1,
                  59'd1_000_000_100, 1'b0, 1'b0, 1, 59'd968_000_000, 59'd1_000_000_100);
    endtask

    task automatic test_residence_violation();
        run_frame("residence", 32'h33, 5'd7, 59'd1_000_000_000, 59'd2_000_000_000, 59'd0, 59'd1000, 1'b1,
                  59'd2_240_000_000, 1'b1, 1'b0, 0, 59'd0, 59'd0);
`ifdef ATS_STATS_EN
        checks++;
        if (stat_pass_cnt !== 32'd2 || stat_drop_cnt !== 32'd1) begin
            errors++; $display("FAIL stats: got pass=%0d drop=%0d want 2/1", stat_pass_cnt, stat_drop_cnt);
        end
`endif
    endtask

    task automatic test_timeout();
        run_frame("timeout", 32'h44, 5'd1, 59'd5_000, 59'd0, 59'd0, 59'd0, 1'b0,
                  59'd0, 1'b1, 1'b1, 0, 59'd0, 59'd0);
    endtask

    task automatic test_reset_mid_op();
        int n;
        upd_cnt = 0;
        ov_cnt = 0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_flow_id = 32'h55; in_group_id = 5'd2;
        in_frame_len = 16'd1500; in_arrival_time = 59'd1_000_000_000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        // Manager stays busy, so the DUT parks in WAIT_MGR.
        bucket_size = 32'd3200; token_rate = 32'd160000;
        bucket_empty_time = '0; group_eligibility_time = '0; max_residence_time = '0;
        match_finish_flag = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL midop_reset_outputs: got %h want 0", all_outs);
        end
        match_finish_flag = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (upd_cnt !== 0 || ov_cnt !== 0) begin
            errors++; $display("FAIL midop_no_activity: got upd=%0d valid=%0d want 0/0", upd_cnt, ov_cnt);
        end
        run_frame("after_reset", 32'h66, 5'd4, 59'd1_000_000_000, 59'd0, 59'd0, 59'd0, 1'b1,
                  59'd1_000_000_000, 1'b0, 1'b0, 1, 59'd728_000_000, 59'd1_000_000_000);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_residence_violation();
        test_timeout();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ats_eligibility_calc.md
Name: ats_eligibility_calc

Overview:
- Per-frame ATS (802.1Qcr token-bucket) eligibility-time stage directly downstream of the flow-entry manager.
- Takes a frame descriptor and requests a parameter lookup from the manager.
- Computes the eligibility time, decides pass or discard, and writes back the new bucket-empty and group-eligibility times.
- Sends the result to the queue-assignment stage over a valid/ready handshake.

Parameters:
- TIME_WIDTH, 59, width of all time values (unit: ps).
- LEN_WIDTH, 16, frame length width (bytes).
- MATCH_TIMEOUT, 64, cycles to wait for match_finish_flag before aborting.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low
- in_valid  in  1  descriptor valid
- in_ready  out  1  block accepts descriptor (high only in IDLE)
- in_flow_id  in  32  flow id
- in_group_id  in  5  group id
- in_frame_len  in  LEN_WIDTH  frame length in bytes
- in_arrival_time  in  TIME_WIDTH  arrival timestamp
- start_match_flag  out  1  one-cycle lookup request to manager
- flow_id  out  32  held copy of in_flow_id, to manager
- group_id  out  5  held copy of in_group_id, to manager
- update_flag  out  1  one-cycle write-back request to manager
- update_bucket_empty_time  out  TIME_WIDTH  new bucket-empty time
- update_group_eligibility_time  out  TIME_WIDTH  new group eligibility time
- match_finish_flag  in  1  lookup result valid (manager holds it high 2 cycles)
- bucket_size  in  32  bytes
- token_rate  in  32  ps per byte
- bucket_empty_time, group_eligibility_time, max_residence_time  in  TIME_WIDTH  each, from manager
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_flow_id  out  32  flow id of the result
- out_group_id  out  5  group id of the result
- out_eligibility_time  out  TIME_WIDTH  computed eligibility time
- out_discard  out  1  frame must be dropped
- out_timeout  out  1  lookup timed out (out_discard also set)

Behaviour:
- Reset: all outputs 0, except in_ready=0. FSM goes to IDLE; in_ready rises the cycle after reset deasserts. Reset mid-operation aborts the transaction with no update_flag and no out_valid.
- IDLE: in_ready=1. On in_valid, capture the descriptor into flow_id/group_id/length/arrival, go to REQ.
- REQ: start_match_flag=1 for exactly one cycle; clear the timeout counter; go to WAIT_MATCH.
- WAIT_MATCH: on the first cycle match_finish_flag=1, capture all manager parameters and go to CALC1. Ignore the second high cycle. If the counter reaches MATCH_TIMEOUT, set out_discard=1 and out_timeout=1, with out_eligibility_time=0, and go to OUTPUT.
- CALC1 (registered):
  - lrd = len*token_rate (48 b)
  - etf = bucket_size*token_rate (64 b)
  - Saturate both to TIME_WIDTH.
- CALC2:
  - sched = bucket_empty_time + lrd
  - full = bucket_empty_time + etf
  - limit = arrival + max_residence_time
  - All sums use TIME_WIDTH+1 bits and saturate to all-ones.
- CALC3:
  - elig = max(arrival, group_eligibility_time, sched).
  - discard = (max_residence_time != 0) && (elig > limit). max_residence_time==0 means unlimited.
  - If not discarded: new_empty = (elig < full) ? sched : sat(sched + elig - full), and new_group = elig.
  - Go to WAIT_MGR.
- WAIT_MGR: wait until match_finish_flag==0, which means the manager is in IDLE. If discard, skip straight to OUTPUT. Otherwise go to UPDATE.
- UPDATE: update_flag=1 for one cycle.
- UPD_HOLD: one cycle, then OUTPUT. flow_id, group_id and the update_* values stay stable from UPDATE through UPD_HOLD.
- OUTPUT:
  - out_valid=1 with results held stable until out_ready.
  - Handshake cycle: out_valid drops and the FSM returns to IDLE.
  - in_ready is not asserted in the handshake cycle (no same-cycle accept).
- Latency from in_valid accept to out_valid = 2 + manager lookup latency + 3 + wait + 2 cycles.
- Exactly one transaction is in flight; no pipelining across frames.
- in_valid while not in IDLE is ignored; the upstream stage must hold it.

Optional Feature:
- ATS_STATS_EN: adds outputs stat_pass_cnt[31:0] and stat_drop_cnt[31:0], reset to 0.
  - Each increments on the output handshake, according to out_discard. Both saturate at 0xFFFFFFFF.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Common parameters: token_rate=160000, bucket_size=3200, len=1500, max_res=0.
- First frame: bucket_empty=0, group_elig=0, arrival=1,000,000,000.
  -> out_eligibility_time=1,000,000,000, out_discard=0, single update_flag pulse, update_bucket_empty_time=728,000,000, update_group_eligibility_time=1,000,000,000.
- Back-to-back frame: bucket_empty=728,000,000, group_elig=1,000,000,000, arrival=1,000,000,100.
  -> elig=1,000,000,100, new_empty=968,000,000 (elig < full=1,240,000,000).
- Residence violation: max_res=1000, bucket_empty=2,000,000,000, arrival=1,000,000,000.
  -> out_discard=1, no update_flag, out_eligibility_time=2,240,000,000.
- Manager never asserts match_finish_flag.
  -> after 64 cycles: out_discard=1, out_timeout=1, no update_flag.
- Assert reset during WAIT_MGR.
  -> no update_flag, no out_valid, all outputs 0. The next frame processes correctly.
- With ATS_STATS_EN, run cases 1–3 with out_ready stalled 5 cycles each.
  -> out_valid/results held stable; stat_pass_cnt=2, stat_drop_cnt=1.
